// File: rtl/imuldiv_div_issue_pkg.sv
// Shared definitions for the divide-issue client: op encodings, tag layout and
// the divide-request function codes used by the iterative divider.
package imuldiv_div_issue_pkg;

    localparam logic [1:0] IMULDIV_DIVOP_DIV  = 2'd0;
    localparam logic [1:0] IMULDIV_DIVOP_DIVU = 2'd1;
    localparam logic [1:0] IMULDIV_DIVOP_REM  = 2'd2;
    localparam logic [1:0] IMULDIV_DIVOP_REMU = 2'd3;

    localparam logic IMULDIV_DIVREQ_MSG_FUNC_SIGNED   = 1'b0;
    localparam logic IMULDIV_DIVREQ_MSG_FUNC_UNSIGNED = 1'b1;

    localparam int IMULDIV_DIV_TAG_W = 6;

    typedef struct packed {
        logic       rem_sel;
        logic [4:0] waddr;
    } div_tag_t;

    function automatic logic div_op_is_rem(input logic [1:0] op);
        return (op == IMULDIV_DIVOP_REM) || (op == IMULDIV_DIVOP_REMU);
    endfunction

    function automatic logic div_op_fn(input logic [1:0] op);
        return ((op == IMULDIV_DIVOP_DIVU) || (op == IMULDIV_DIVOP_REMU)) ?
               IMULDIV_DIVREQ_MSG_FUNC_UNSIGNED : IMULDIV_DIVREQ_MSG_FUNC_SIGNED;
    endfunction

endpackage

// File: rtl/imuldiv_div_issue_tag_queue.sv
// imuldiv_div_tag_queue: small synchronous FIFO holding the destination and
// result-select of every operation outstanding in the divider.
module imuldiv_div_tag_queue
    import imuldiv_div_issue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = IMULDIV_DIV_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Explicit wrap keeps non-power-of-two depths safe as well.
    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        if (p == LAST_IDX) begin
            return {AW{1'b0}};
        end else begin
            return p + AW'(1'b1);
        end
    endfunction

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == {CW{1'b0}});
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rptr];

    // Storage write
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    // Pointer and occupancy update
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wptr <= ptr_next(r_wptr);
            end
            if (w_do_pop) begin
                r_rptr <= ptr_next(r_rptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1'b1);
                2'b01:   r_count <= r_count - CW'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/imuldiv_div_issue.sv
// Divide-issue client: forwards div/rem ops to the divider, tracks them in order
// and presents the selected result on a registered writeback port.
// Optional macro IMULDIV_DIV_ZERO_BYPASS_EN completes zero-divisor ops locally.
module imuldiv_div_issue
    import imuldiv_div_issue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_val,
    output logic        in_rdy,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [4:0]  in_waddr,
    output logic        divreq_msg_fn,
    output logic [31:0] divreq_msg_a,
    output logic [31:0] divreq_msg_b,
    output logic        divreq_val,
    input  logic        divreq_rdy,
    input  logic [63:0] divresp_msg_result,
    input  logic        divresp_val,
    output logic        divresp_rdy,
    output logic        wb_val,
    input  logic        wb_rdy,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_waddr
);

    div_tag_t    w_push_tag;
    div_tag_t    w_head_tag;
    logic        w_q_full;
    logic        w_q_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_wb_space;
    logic        w_resp_fire;
    logic        w_byp_fire;
    logic        w_load;
    logic [31:0] w_load_data;
    logic [4:0]  w_load_waddr;
    logic        r_wb_full;
    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_waddr;

    assign divreq_msg_fn = div_op_fn(in_op);
    assign divreq_msg_a  = in_a;
    assign divreq_msg_b  = in_b;

    assign w_wb_space  = !r_wb_full || wb_rdy;
    assign divresp_rdy = w_wb_space;
    assign w_resp_fire = divresp_val && divresp_rdy;
    // A response with nothing outstanding is dropped rather than written back.
    assign w_pop       = w_resp_fire && !w_q_empty;

`ifdef IMULDIV_DIV_ZERO_BYPASS_EN
    logic w_byp_cand;
    logic w_byp_ok;

    assign w_byp_cand = in_val && (in_b == 32'd0);
    // Empty queue guarantees the local result cannot overtake a divider result.
    assign w_byp_ok   = w_q_empty && w_wb_space;
    assign w_byp_fire = w_byp_cand && w_byp_ok;
    assign divreq_val = in_val && !w_q_full && !w_byp_cand;
    assign in_rdy     = w_byp_cand ? w_byp_ok : (divreq_rdy && !w_q_full);
`else
    assign w_byp_fire = 1'b0;
    assign divreq_val = in_val && !w_q_full;
    assign in_rdy     = divreq_rdy && !w_q_full;
`endif

    assign w_push             = divreq_val && divreq_rdy;
    assign w_push_tag.rem_sel = div_op_is_rem(in_op);
    assign w_push_tag.waddr   = in_waddr;

    imuldiv_div_tag_queue #(
        .DEPTH (DEPTH),
        .WIDTH (IMULDIV_DIV_TAG_W)
    ) u_tag_queue (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_tag),
        .i_pop       (w_pop),
        .o_head      (w_head_tag),
        .o_full      (w_q_full),
        .o_empty     (w_q_empty)
    );

    // Select what, if anything, loads the writeback register this cycle
    always_comb begin
        w_load       = 1'b0;
        w_load_data  = 32'd0;
        w_load_waddr = 5'd0;
        if (w_pop) begin
            w_load       = 1'b1;
            w_load_data  = w_head_tag.rem_sel ? divresp_msg_result[63:32]
                                              : divresp_msg_result[31:0];
            w_load_waddr = w_head_tag.waddr;
        end else if (w_byp_fire) begin
            w_load       = 1'b1;
            w_load_data  = div_op_is_rem(in_op) ? in_a : 32'hFFFF_FFFF;
            w_load_waddr = in_waddr;
        end else begin
            w_load       = 1'b0;
        end
    end

    // Writeback holding register; a load in the drain cycle keeps it full
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_full  <= 1'b0;
            r_wb_data  <= 32'd0;
            r_wb_waddr <= 5'd0;
        end else if (w_load) begin
            r_wb_full  <= 1'b1;
            r_wb_data  <= w_load_data;
            r_wb_waddr <= w_load_waddr;
        end else if (wb_rdy) begin
            r_wb_full  <= 1'b0;
        end
    end

    assign wb_val   = r_wb_full;
    assign wb_data  = r_wb_data;
    assign wb_waddr = r_wb_waddr;

endmodule
